// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared opcode/result-class codes and datapath constants for
// the execute stage and its neighbours.
//   - EXE_*_OP   : aluop codes driven by decode
//   - EXE_RES_*  : alusel result classes
//   - RstEnable / WriteEnable / ZeroWord : common constants
//   - RegBus / RegAddrBus / AluOpBus / AluSelBus : default bus widths
package ex_stage_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int AluOpBus   = 8;
  localparam int AluSelBus  = 3;

  localparam logic              RstEnable   = 1'b1;
  localparam logic              WriteEnable = 1'b1;
  localparam logic [RegBus-1:0] ZeroWord    = '0;

  typedef logic [AluOpBus-1:0]  alu_op_t;
  typedef logic [AluSelBus-1:0] alu_sel_t;

  // aluop codes
  localparam alu_op_t EXE_NOP_OP  = 8'h00;
  localparam alu_op_t EXE_AND_OP  = 8'h24;
  localparam alu_op_t EXE_OR_OP   = 8'h25;
  localparam alu_op_t EXE_XOR_OP  = 8'h26;
  localparam alu_op_t EXE_NOR_OP  = 8'h27;
  localparam alu_op_t EXE_SLL_OP  = 8'h7C;
  localparam alu_op_t EXE_SRL_OP  = 8'h02;
  localparam alu_op_t EXE_SRA_OP  = 8'h03;
  localparam alu_op_t EXE_MOVZ_OP = 8'h0A;
  localparam alu_op_t EXE_MOVN_OP = 8'h0B;
  localparam alu_op_t EXE_MFHI_OP = 8'h10;
  localparam alu_op_t EXE_MTHI_OP = 8'h11;
  localparam alu_op_t EXE_MFLO_OP = 8'h12;
  localparam alu_op_t EXE_MTLO_OP = 8'h13;

  // alusel result classes
  localparam alu_sel_t EXE_RES_NOP   = 3'b000;
  localparam alu_sel_t EXE_RES_LOGIC = 3'b001;
  localparam alu_sel_t EXE_RES_SHIFT = 3'b010;
  localparam alu_sel_t EXE_RES_MOVE  = 3'b011;

endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: decode->EX operands, EX->decode forward bus, EX->MEM register
// outputs and HI/LO view.
//   master : upstream/testbench side (drives *_i, stall/flush; reads outputs)
//   slave  : ex_stage side
interface ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) ();
  import ex_stage_pkg::*;

  alu_op_t             aluop_i;
  alu_sel_t            alusel_i;
  logic [DATA_W-1:0]   reg1_i;
  logic [DATA_W-1:0]   reg2_i;
  logic [ADDR_W-1:0]   wd_i;
  logic                wreg_i;
  logic                stall_i;
  logic                flush_i;

  logic                ex_wreg_o;
  logic [ADDR_W-1:0]   ex_wd_o;
  logic [DATA_W-1:0]   ex_wdata_o;
  logic                mem_wreg_o;
  logic [ADDR_W-1:0]   mem_wd_o;
  logic [DATA_W-1:0]   mem_wdata_o;
  logic [DATA_W-1:0]   hi_o;
  logic [DATA_W-1:0]   lo_o;

  modport master (
    output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, stall_i, flush_i,
    input  ex_wreg_o, ex_wd_o, ex_wdata_o,
    input  mem_wreg_o, mem_wd_o, mem_wdata_o, hi_o, lo_o
  );

  modport slave (
    input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, stall_i, flush_i,
    output ex_wreg_o, ex_wd_o, ex_wdata_o,
    output mem_wreg_o, mem_wd_o, mem_wdata_o, hi_o, lo_o
  );
endinterface

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register.
//   clk, rst        : clock, async active-high reset
//   stall_i/flush_i : flush loads a bubble, stall holds, else load (flush wins)
//   wreg/wd/wdata_i : result of the instruction leaving EX
//   mem_*_o         : registered copy handed to MEM
module ex_mem_reg
  import ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              wreg_i,
  input  logic [ADDR_W-1:0] wd_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              mem_wreg_o,
  output logic [ADDR_W-1:0] mem_wd_o,
  output logic [DATA_W-1:0] mem_wdata_o
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      mem_wreg_o  <= 1'b0;
      mem_wd_o    <= '0;
      mem_wdata_o <= '0;
    end else if (flush_i) begin
      mem_wreg_o  <= 1'b0;
      mem_wd_o    <= '0;
      mem_wdata_o <= '0;
    end else if (!stall_i) begin
      mem_wreg_o  <= wreg_i;
      mem_wd_o    <= wd_i;
      mem_wdata_o <= wdata_i;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage. Computes logic/shift/move results, owns HI/LO,
// forwards the combinational result to decode and registers it into EX/MEM.
//   clk, rst : clock, async active-high reset
//   bus      : ex_stage_if slave (decode operands, stall/flush, forward bus,
//              EX/MEM outputs, HI/LO)
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DATA_W = RegBus,
  parameter int ADDR_W = RegAddrBus
) (
  input  logic     clk,
  input  logic     rst,
  ex_stage_if.slave bus
);

  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W-1:0] hi_q, lo_q;
  logic [DATA_W-1:0] logic_res, shift_res, move_res, result;
  logic [SH_W-1:0]   shamt;
  logic              commit;

  assign shamt  = bus.reg1_i[SH_W-1:0];
  assign commit = !bus.stall_i && !bus.flush_i;

  always_comb begin
    logic_res = '0;
    unique case (bus.aluop_i)
      EXE_AND_OP: logic_res = bus.reg1_i & bus.reg2_i;
      EXE_OR_OP:  logic_res = bus.reg1_i | bus.reg2_i;
      EXE_XOR_OP: logic_res = bus.reg1_i ^ bus.reg2_i;
      EXE_NOR_OP: logic_res = ~(bus.reg1_i | bus.reg2_i);
      default:    logic_res = '0;
    endcase
  end

  always_comb begin
    shift_res = '0;
    unique case (bus.aluop_i)
      EXE_SLL_OP: shift_res = bus.reg2_i << shamt;
      EXE_SRL_OP: shift_res = bus.reg2_i >> shamt;
      EXE_SRA_OP: shift_res = DATA_W'($signed(bus.reg2_i) >>> shamt);
      default:    shift_res = '0;
    endcase
  end

  // MOVZ/MOVN: the zero/non-zero test already happened in decode via wreg_i.
  always_comb begin
    move_res = '0;
    unique case (bus.aluop_i)
      EXE_MFHI_OP: move_res = hi_q;
      EXE_MFLO_OP: move_res = lo_q;
      EXE_MOVZ_OP,
      EXE_MOVN_OP: move_res = bus.reg1_i;
      default:     move_res = '0;
    endcase
  end

  always_comb begin
    result = '0;
    unique case (bus.alusel_i)
      EXE_RES_LOGIC: result = logic_res;
      EXE_RES_SHIFT: result = shift_res;
      EXE_RES_MOVE:  result = move_res;
      default:       result = '0;
    endcase
  end

  // HI/LO commit at end of EX; MFHI/MFLO in the following cycle reads the
  // register directly, so no bypass path is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit) begin
      if (bus.aluop_i == EXE_MTHI_OP) hi_q <= bus.reg1_i;
      if (bus.aluop_i == EXE_MTLO_OP) lo_q <= bus.reg1_i;
    end
  end

  assign bus.ex_wreg_o  = bus.wreg_i;
  assign bus.ex_wd_o    = bus.wd_i;
  assign bus.ex_wdata_o = result;
  assign bus.hi_o       = hi_q;
  assign bus.lo_o       = lo_q;

  ex_mem_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ex_mem_reg (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (bus.stall_i),
    .flush_i     (bus.flush_i),
    .wreg_i      (bus.wreg_i),
    .wd_i        (bus.wd_i),
    .wdata_i     (result),
    .mem_wreg_o  (bus.mem_wreg_o),
    .mem_wd_o    (bus.mem_wd_o),
    .mem_wdata_o (bus.mem_wdata_o)
  );

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad   = 0;

  ex_stage_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  ex_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [4:0] wd, input logic wreg);
    bus.aluop_i  = op;
    bus.alusel_i = sel;
    bus.reg1_i   = r1;
    bus.reg2_i   = r2;
    bus.wd_i     = wd;
    bus.wreg_i   = wreg;
  endtask

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    total++; if (bus.mem_wreg_o !== 1'b0) begin bad++; $display("FAIL reset_mem_wreg got=%0b exp=0", bus.mem_wreg_o); end
    total++; if (bus.mem_wdata_o !== 32'h0) begin bad++; $display("FAIL reset_mem_wdata got=%h exp=0", bus.mem_wdata_o); end
    total++; if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0) begin bad++; $display("FAIL reset_hilo got=%h/%h exp=0/0", bus.hi_o, bus.lo_o); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_logic();
    @(negedge clk); drive(EXE_OR_OP, EXE_RES_LOGIC, 32'h0F0F0000, 32'h00FF00FF, 5'd5, 1'b1);
    #1;
    total++; if (bus.ex_wdata_o !== 32'h0FFF00FF) begin bad++; $display("FAIL or_ex got=%h exp=0fff00ff", bus.ex_wdata_o); end
    total++; if (bus.ex_wd_o !== 5'd5 || bus.ex_wreg_o !== 1'b1) begin bad++; $display("FAIL or_fwd got=%0d/%0b exp=5/1", bus.ex_wd_o, bus.ex_wreg_o); end
    edge1();
    total++; if (bus.mem_wdata_o !== 32'h0FFF00FF) begin bad++; $display("FAIL or_mem got=%h exp=0fff00ff", bus.mem_wdata_o); end
    total++; if (bus.mem_wd_o !== 5'd5 || bus.mem_wreg_o !== 1'b1) begin bad++; $display("FAIL or_mem_wd got=%0d/%0b exp=5/1", bus.mem_wd_o, bus.mem_wreg_o); end
    @(negedge clk); bus.aluop_i = EXE_NOR_OP; #1;
    total++; if (bus.ex_wdata_o !== 32'hF000FF00) begin bad++; $display("FAIL nor_ex got=%h exp=f000ff00", bus.ex_wdata_o); end
    @(negedge clk); bus.aluop_i = EXE_AND_OP; #1;
    total++; if (bus.ex_wdata_o !== 32'h000F0000) begin bad++; $display("FAIL and_ex got=%h exp=000f0000", bus.ex_wdata_o); end
    @(negedge clk); bus.aluop_i = EXE_XOR_OP; #1;
    total++; if (bus.ex_wdata_o !== 32'h0FF000FF) begin bad++; $display("FAIL xor_ex got=%h exp=0ff000ff", bus.ex_wdata_o); end
  endtask

  task automatic test_shift();
    @(negedge clk); drive(EXE_SRA_OP, EXE_RES_SHIFT, 32'hFFFFFFE4, 32'h80000010, 5'd6, 1'b1);
    #1;
    total++; if (bus.ex_wdata_o !== 32'hF8000001) begin bad++; $display("FAIL sra got=%h exp=f8000001", bus.ex_wdata_o); end
    @(negedge clk); bus.aluop_i = EXE_SRL_OP; #1;
    total++; if (bus.ex_wdata_o !== 32'h08000001) begin bad++; $display("FAIL srl got=%h exp=08000001", bus.ex_wdata_o); end
    @(negedge clk); bus.aluop_i = EXE_SLL_OP; #1;
    total++; if (bus.ex_wdata_o !== 32'h00000100) begin bad++; $display("FAIL sll got=%h exp=00000100", bus.ex_wdata_o); end
    edge1();
    total++; if (bus.mem_wdata_o !== 32'h00000100 || bus.mem_wd_o !== 5'd6) begin bad++; $display("FAIL sll_mem got=%h/%0d exp=00000100/6", bus.mem_wdata_o, bus.mem_wd_o); end
  endtask

  task automatic test_hilo();
    @(negedge clk); drive(EXE_MTHI_OP, EXE_RES_NOP, 32'h12345678, 32'h0, 5'd0, 1'b0);
    #1;
    total++; if (bus.hi_o !== 32'h0 || bus.ex_wreg_o !== 1'b0) begin bad++; $display("FAIL mthi_pre got=%h/%0b exp=0/0", bus.hi_o, bus.ex_wreg_o); end
    edge1();
    total++; if (bus.hi_o !== 32'h12345678) begin bad++; $display("FAIL mthi got=%h exp=12345678", bus.hi_o); end
    @(negedge clk); drive(EXE_MFHI_OP, EXE_RES_MOVE, 32'h0, 32'h0, 5'd3, 1'b1); #1;
    total++; if (bus.ex_wdata_o !== 32'h12345678) begin bad++; $display("FAIL mfhi got=%h exp=12345678", bus.ex_wdata_o); end
    @(negedge clk); drive(EXE_MTLO_OP, EXE_RES_NOP, 32'hDEADBEEF, 32'h0, 5'd0, 1'b0);
    bus.stall_i = 1'b1;
    edge1();
    total++; if (bus.lo_o !== 32'h0) begin bad++; $display("FAIL mtlo_stall got=%h exp=0", bus.lo_o); end
    @(negedge clk); bus.stall_i = 1'b0;
    edge1();
    total++; if (bus.lo_o !== 32'hDEADBEEF) begin bad++; $display("FAIL mtlo got=%h exp=deadbeef", bus.lo_o); end
    @(negedge clk); drive(EXE_MFLO_OP, EXE_RES_MOVE, 32'h0, 32'h0, 5'd4, 1'b1); #1;
    total++; if (bus.ex_wdata_o !== 32'hDEADBEEF) begin bad++; $display("FAIL mflo got=%h exp=deadbeef", bus.ex_wdata_o); end
    @(negedge clk); drive(EXE_MOVN_OP, EXE_RES_MOVE, 32'hA5A5A5A5, 32'h1, 5'd4, 1'b1); #1;
    total++; if (bus.ex_wdata_o !== 32'hA5A5A5A5) begin bad++; $display("FAIL movn got=%h exp=a5a5a5a5", bus.ex_wdata_o); end
  endtask

  task automatic test_stall_flush();
    @(negedge clk); drive(EXE_OR_OP, EXE_RES_LOGIC, 32'h0F0F0000, 32'h00FF00FF, 5'd5, 1'b1);
    edge1();
    @(negedge clk); drive(EXE_XOR_OP, EXE_RES_LOGIC, 32'hFFFFFFFF, 32'h1, 5'd7, 1'b0);
    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      edge1();
      total++;
      if (bus.mem_wdata_o !== 32'h0FFF00FF || bus.mem_wd_o !== 5'd5 || bus.mem_wreg_o !== 1'b1) begin
        bad++; $display("FAIL stall_hold[%0d] got=%h/%0d/%0b exp=0fff00ff/5/1", i, bus.mem_wdata_o, bus.mem_wd_o, bus.mem_wreg_o);
      end
    end
    @(negedge clk); drive(EXE_MTHI_OP, EXE_RES_NOP, 32'hCAFEF00D, 32'h0, 5'd0, 1'b0);
    bus.flush_i = 1'b1;
    edge1();
    total++; if (bus.mem_wreg_o !== 1'b0 || bus.mem_wdata_o !== 32'h0 || bus.mem_wd_o !== 5'd0) begin bad++; $display("FAIL flush_stall got=%h/%0d/%0b exp=0/0/0", bus.mem_wdata_o, bus.mem_wd_o, bus.mem_wreg_o); end
    total++; if (bus.hi_o !== 32'h12345678) begin bad++; $display("FAIL flush_hi got=%h exp=12345678", bus.hi_o); end
    @(negedge clk); bus.stall_i = 1'b0; bus.aluop_i = EXE_MTLO_OP;
    edge1();
    total++; if (bus.lo_o !== 32'hDEADBEEF) begin bad++; $display("FAIL flush_lo got=%h exp=deadbeef", bus.lo_o); end
    @(negedge clk); bus.flush_i = 1'b0; drive(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  task automatic test_unknown();
    @(negedge clk); drive(8'hFF, 3'b111, 32'h12345678, 32'h9ABCDEF0, 5'd9, 1'b1); #1;
    total++; if (bus.ex_wdata_o !== 32'h0) begin bad++; $display("FAIL unk_ex got=%h exp=0", bus.ex_wdata_o); end
    total++; if (bus.ex_wreg_o !== 1'b1 || bus.ex_wd_o !== 5'd9) begin bad++; $display("FAIL unk_fwd got=%0b/%0d exp=1/9", bus.ex_wreg_o, bus.ex_wd_o); end
    edge1();
    total++; if (bus.mem_wdata_o !== 32'h0 || bus.mem_wreg_o !== 1'b1 || bus.mem_wd_o !== 5'd9) begin bad++; $display("FAIL unk_mem got=%h/%0b/%0d exp=0/1/9", bus.mem_wdata_o, bus.mem_wreg_o, bus.mem_wd_o); end
  endtask

  task automatic test_async_reset();
    @(negedge clk); drive(EXE_OR_OP, EXE_RES_LOGIC, 32'h0F0F0000, 32'h00FF00FF, 5'd5, 1'b1);
    edge1();
    @(negedge clk); bus.stall_i = 1'b1;
    #2; rst = 1'b1; #1;
    total++; if (bus.mem_wreg_o !== 1'b0 || bus.mem_wd_o !== 5'd0 || bus.mem_wdata_o !== 32'h0) begin bad++; $display("FAIL async_rst_mem got=%h/%0d/%0b exp=0/0/0", bus.mem_wdata_o, bus.mem_wd_o, bus.mem_wreg_o); end
    total++; if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0) begin bad++; $display("FAIL async_rst_hilo got=%h/%h exp=0/0", bus.hi_o, bus.lo_o); end
    drive(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    bus.stall_i = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    drive(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    test_reset();
    test_logic();
    test_shift();
    test_hilo();
    test_stall_flush();
    test_unknown();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
